// File: rtl/hamming_encoder_stream.sv
// rtl/hamming_encoder_stream.sv - streaming SECDED Hamming(16,11) encoder with error injection and output FIFO
// Codewords are indexed [16:1]; position k of the codeword is bit k of out_code.
module hamming_encoder_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [10:0]              in_data,
  input  logic [15:0]              in_inj,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [16:1]              out_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         word_count,
  output logic [CNT_W-1:0]         inj_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  function automatic logic [16:1] encode(input logic [10:0] d);
    logic [16:1] c;
    c     = '0;
    c[3]  = d[0];
    c[5]  = d[1];
    c[6]  = d[2];
    c[7]  = d[3];
    c[9]  = d[4];
    c[10] = d[5];
    c[11] = d[6];
    c[12] = d[7];
    c[13] = d[8];
    c[14] = d[9];
    c[15] = d[10];
    c[1]  = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
    c[2]  = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
    c[4]  = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    c[8]  = c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    // Overall parity covers the clean word so injection can also corrupt position 16.
    c[16] = ^c[15:1];
    return c;
  endfunction

  logic [16:1]      mem_q [DEPTH];
  logic [16:1]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [CNT_W-1:0] inj_count_q, inj_count_d;

  logic        push;
  logic        pop;
  logic [16:1] inj_code;

  assign in_ready   = (level_q != FULL_LVL);
  assign out_valid  = (level_q != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign inj_code   = encode(in_data) ^ in_inj;
  assign out_code   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level      = level_q;
  assign word_count = word_count_q;
  assign inj_count  = inj_count_q;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    word_count_d = word_count_q;
    inj_count_d  = inj_count_q;
    if (push) begin
      mem_d[wr_ptr_q] = inj_code;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      word_count_d    = word_count_q + CNT_W'(1);
      if (in_inj != '0) begin
        inj_count_d = inj_count_q + CNT_W'(1);
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      word_count_q <= '0;
      inj_count_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      word_count_q <= word_count_d;
      inj_count_q  <= inj_count_d;
    end
  end

  // Storage is not reset; out_code masks it to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// tb/tb_hamming_encoder_stream.sv - scoreboard bench for hamming_encoder_stream
// Expected codewords come from a generic Hamming position model; a monitor compares pops in order.
module tb_hamming_encoder_stream;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [10:0]            in_data;
  logic [15:0]            in_inj;
  logic                   in_valid;
  logic                   in_ready;
  logic [16:1]            out_code;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       word_count;
  logic [CNT_W-1:0]       inj_count;

  hamming_encoder_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_inj     (in_inj),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_code   (out_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .word_count (word_count),
    .inj_count  (inj_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_word_count = '0;
  logic [15:0] exp_inj_count = '0;
  logic [15:0] mon_exp;
  int          ready_mode = 2;
  int          stalls = 0;
  int          pops = 0;
  int          max_level = 0;
  bit          stream_on = 1'b0;

  // Data fills non-power-of-two positions in order; parity p covers positions with bit p set.
  function automatic logic [15:0] ref_encode(input logic [10:0] d);
    logic [16:1] c;
    int j;
    c = '0;
    j = 0;
    for (int k = 1; k <= 15; k++) begin
      if ((k & (k - 1)) != 0) begin
        c[k] = d[j];
        j++;
      end
    end
    for (int p = 1; p <= 8; p = p * 2) begin
      for (int k = 1; k <= 15; k++) begin
        if (((k & p) != 0) && (k != p)) c[p] = c[p] ^ c[k];
      end
    end
    c[16] = ^c[15:1];
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_output: got %0h expected no word", out_code);
      end else begin
        mon_exp = exp_q.pop_front();
        check("fifo_order", 32'(out_code), 32'(mon_exp));
        pops++;
      end
    end
    if (stream_on && int'(level) > max_level) max_level = int'(level);
  end

  task automatic send(input logic [10:0] d, input logic [15:0] inj);
    int n;
    n = 0;
    in_data  = d;
    in_inj   = inj;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    stalls += n;
    if (in_ready) begin
      exp_q.push_back(ref_encode(d) ^ inj);
      exp_word_count++;
      if (inj != '0) exp_inj_count++;
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic set_ready(input int mode);
    ready_mode = mode;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    ready_mode = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && !out_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    exp_word_count = '0;
    exp_inj_count  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic directed(input string name, input logic [10:0] d, input logic [15:0] inj,
                          input logic [15:0] code);
    set_ready(2);
    send(d, inj);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check(name, 32'(out_code), 32'(code));
    wait_empty();
  endtask

  function automatic logic [15:0] rand_inj();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'h0001 << $urandom_range(0, 15);
      2:       return (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  logic [15:0] held;
  int          pops0;

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_inj    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_code", 32'(out_code), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_inj_count", 32'(inj_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    directed("enc_000", 11'h000, 16'h0000, 16'h0000);
    directed("enc_001", 11'h001, 16'h0000, 16'h8007);
    directed("enc_7ff", 11'h7FF, 16'h0000, 16'hFFFF);
    directed("inj_single", 11'h000, 16'h0020, 16'h0020);
    check("inj_count_1", 32'(inj_count), 32'd1);
    directed("inj_double", 11'h001, 16'h0003, 16'h8004);
    check("inj_count_2", 32'(inj_count), 32'd2);
    check("word_count_5", 32'(word_count), 32'd5);

    do_reset();
    set_ready(2);
    for (int i = 0; i < DEPTH; i++) send(11'($urandom), rand_inj());
    @(negedge clk);
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_in_ready", 32'(in_ready), 32'd0);
    held = out_code;
    in_data  = 11'($urandom);
    in_inj   = 16'hFFFF;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("full_word_count", 32'(word_count), 32'(DEPTH));
    check("full_head_stable", 32'(out_code), 32'(held));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_empty();

    do_reset();
    set_ready(0);
    stalls    = 0;
    max_level = 0;
    pops0     = pops;
    stream_on = 1'b1;
    for (int i = 0; i < 100; i++) send(11'($urandom), 16'h0000);
    wait_empty();
    stream_on = 1'b0;
    check("stream_word_count", 32'(word_count), 32'd100);
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_max_level", 32'(max_level <= 1), 32'd1);
    check("stream_pops", 32'(pops - pops0), 32'd100);

    set_ready(2);
    for (int i = 0; i < 3; i++) send(11'($urandom), rand_inj());
    @(negedge clk);
    check("mid_level3", 32'(level), 32'd3);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 11'h155;
    in_inj   = 16'h0101;
    exp_q.delete();
    exp_word_count = '0;
    exp_inj_count  = '0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_level", 32'(level), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_word_count", 32'(word_count), 32'd0);
    check("mid_inj_count", 32'(inj_count), 32'd0);
    check("mid_out_code", 32'(out_code), 32'd0);
    set_ready(0);
    repeat (5) @(negedge clk);
    check("mid_no_stale", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    directed("post_rst", 11'h2A5, 16'h0000, ref_encode(11'h2A5));

    set_ready(1);
    for (int i = 0; i < 300; i++) begin
      send(11'($urandom), rand_inj());
      if ($urandom_range(0, 3) == 0) begin
        in_data = 11'($urandom);
        in_inj  = 16'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_empty();
    check("final_word_count", 32'(word_count), 32'(exp_word_count));
    check("final_inj_count", 32'(inj_count), 32'(exp_inj_count));
    check("final_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2000000");
    $fatal(1);
  end

endmodule
